// File: rtl/bitty_core.sv
// Multi-cycle Bitty core: IDLE/LOAD/EXEC/WB sequencer over an NUM_REGS x DATA_W register file.
// Optional feature macro BITTY_IMM_EN enables the fmt 01 zero-extended imm8 operand.
module bitty_core #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [15:0]                instruction,
  input  logic                       inst_valid,
  output logic                       inst_ready,
  output logic                       done,
  output logic [NUM_REGS*DATA_W-1:0] reg_flat,
  output logic [DATA_W-1:0]          reg_c
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int SW = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, WB} state_e;
  state_e state_q, state_d;

  logic [15:0]                      inst_q;
  logic [DATA_W-1:0]                s_q, c_q;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q;
  logic                             done_q;

  logic [RW-1:0]     rx, ry;
  logic [2:0]        op;
  logic [1:0]        fmt;
  logic [DATA_W-1:0] opb, alu;
  logic [SW-1:0]     shamt;
  logic              fmt_ok;
  logic              unused_inst;

  assign rx  = inst_q[13 +: RW];
  assign ry  = inst_q[10 +: RW];
  assign op  = inst_q[4:2];
  assign fmt = inst_q[1:0];
  // Upper index bits and imm bits are don't-care in some builds.
  assign unused_inst = ^inst_q;

  // fmt_ok gates both the C update and the write-back, so reserved formats retire as no-ops.
  always_comb begin
    opb    = regs_q[ry];
    fmt_ok = (fmt == 2'b00);
`ifdef BITTY_IMM_EN
    if (fmt == 2'b01) begin
      opb    = DATA_W'(inst_q[12:5]);
      fmt_ok = 1'b1;
    end
`endif
  end

  always_comb begin
    shamt = opb[SW-1:0];
    case (op)
      3'd0:    alu = s_q + opb;
      3'd1:    alu = s_q - opb;
      3'd2:    alu = s_q & opb;
      3'd3:    alu = s_q | opb;
      3'd4:    alu = s_q ^ opb;
      3'd5:    alu = s_q << shamt;
      3'd6:    alu = s_q >> shamt;
      default: alu = (s_q == opb) ? '0 : (s_q > opb) ? DATA_W'(1) : DATA_W'(2);
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (inst_valid) state_d = LOAD;
      LOAD:    state_d = EXEC;
      EXEC:    state_d = WB;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inst_ready = (state_q == IDLE);
    done       = done_q;
    reg_flat   = regs_q;
    reg_c      = c_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_q <= '0;
      s_q    <= '0;
      c_q    <= '0;
      regs_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == WB);
      if (state_q == IDLE && inst_valid) inst_q <= instruction;
      if (state_q == LOAD)               s_q    <= regs_q[rx];
      if (state_q == EXEC && fmt_ok)     c_q    <= alu;
      if (state_q == WB && fmt_ok)       regs_q[rx] <= c_q;
    end
  end
endmodule

// File: tb/tb_bitty_core.sv
// Scoreboard bench for bitty_core: the driver pushes hand-computed results, a monitor checks them on done.
module tb_bitty_core;
  localparam int DW = 16;
  localparam int NR = 8;
  localparam int CW = NR*DW;

  typedef struct {
    logic [CW-1:0] regs;
    logic [DW-1:0] c;
    int            acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          inst_valid = 1'b0;
  logic [15:0]   instruction = '0;
  logic          inst_ready, done;
  logic [CW-1:0] reg_flat;
  logic [DW-1:0] reg_c;

  int checks = 0, failures = 0, cyc = 0, last_acc = -100;
  exp_t sb[$];
  exp_t e;
  logic [NR-1:0][DW-1:0] mregs = '0;
  logic [DW-1:0]         mc = '0;

  bitty_core #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .done(done), .reg_flat(reg_flat), .reg_c(reg_c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Monitor: busy window must hold inst_ready low; each done retires one scoreboard entry.
  always @(negedge clk) begin
    if (reset) begin
      if (cyc >= last_acc && cyc <= last_acc + 2)
        checki("ready_low_busy", int'(inst_ready), 0);
      if (done) begin
        if (sb.size() == 0) checki("spurious_done", int'(done), 0);
        else begin
          e = sb.pop_front();
          checki("done_latency", cyc - e.acc, 3);
          checki("retire_ready", int'(inst_ready), 1);
          check("retire_regs", reg_flat, e.regs);
          check("retire_c", CW'(reg_c), CW'(e.c));
        end
      end
    end
  end

  // Present ins now (at a negedge) and wait for it to be taken at a rising edge.
  task automatic issue_now(input logic [15:0] ins, input logic wr,
                           input logic [DW-1:0] val, input logic [DW-1:0] c, input int gap);
    int n = 0;
    instruction = ins;
    inst_valid  = 1'b1;
    while (!inst_ready && n < 16) begin @(negedge clk); n++; end
    if (!inst_ready) begin
      checki("accept_timeout", int'(inst_ready), 1);
      return;
    end
    if (gap > 0) checki("accept_gap", cyc + 1 - last_acc, gap);
    last_acc = cyc + 1;
    if (wr) begin
      mregs[ins[15:13]] = val;
      mc = c;
    end
    sb.push_back('{regs: mregs, c: mc, acc: cyc + 1});
    @(posedge clk);
  endtask

  task automatic issue(input logic [15:0] ins, input logic wr,
                       input logic [DW-1:0] val, input logic [DW-1:0] c, input int gap);
    @(negedge clk);
    issue_now(ins, wr, val, c, gap);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    inst_valid = 1'b0;
    while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    checki("drain_timeout", sb.size(), 0);
  endtask

  task automatic idle_window(input int cycles);
    instruction = 16'h00A1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checki("idle_done", int'(done), 0);
      checki("idle_ready", int'(inst_ready), 1);
      check("idle_regs", reg_flat, mregs);
      check("idle_c", CW'(reg_c), CW'(mc));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    inst_valid = 1'b0;
    sb.delete();
    last_acc = -100;
    mregs = '0;
    mc = '0;
    @(negedge clk);
    check("rst_regs", reg_flat, '0);
    check("rst_c", CW'(reg_c), '0);
    checki("rst_ready", int'(inst_ready), 1);
    checki("rst_done", int'(done), 0);
    reset = 1'b1;
  endtask

  // Abort during EXEC: nothing may retire; then accept at the first edge after release.
  task automatic mid_reset(input logic [15:0] after, input logic wr,
                           input logic [DW-1:0] val, input logic [DW-1:0] c);
    issue(16'h00A1, 1'b0, '0, '0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    inst_valid = 1'b0;
    sb.delete();
    last_acc = -100;
    mregs = '0;
    mc = '0;
    #1;
    check("midrst_regs", reg_flat, '0);
    checki("midrst_done", int'(done), 0);
    @(negedge clk);
    checki("midrst_done_held", int'(done), 0);
    reset = 1'b1;
    checki("release_ready", int'(inst_ready), 1);
    issue_now(after, wr, val, c, 0);
  endtask

  initial begin
    #1;
    do_reset();
`ifdef BITTY_IMM_EN
    issue(16'h00A1, 1'b1, 16'h0005, 16'h0005, 0);
    issue(16'h2061, 1'b1, 16'h0003, 16'h0003, 4);
    issue(16'h0404, 1'b1, 16'h0002, 16'h0002, 4);
    issue(16'h4404, 1'b1, 16'hFFFD, 16'hFFFD, 4);
    issue(16'h201C, 1'b1, 16'h0001, 16'h0001, 4);
    issue(16'h001C, 1'b1, 16'h0000, 16'h0000, 4);
    issue(16'h7E01, 1'b1, 16'h00F0, 16'h00F0, 4);
    issue(16'h6789, 1'b1, 16'h0030, 16'h0030, 4);
    issue(16'h61ED, 1'b1, 16'h003F, 16'h003F, 4);
    issue(16'h6810, 1'b1, 16'hFFC2, 16'hFFC2, 4);
    issue(16'h6095, 1'b1, 16'hFC20, 16'hFC20, 4);
    issue(16'h6319, 1'b1, 16'h00FC, 16'h00FC, 4);
    issue(16'h2C1C, 1'b1, 16'h0002, 16'h0002, 4);
    issue(16'h00A3, 1'b0, '0, '0, 4);
    issue(16'h00A2, 1'b0, '0, '0, 4);
    drain();
    idle_window(10);
    issue(16'h80E1, 1'b1, 16'h0007, 16'h0007, 0);
    issue(16'h9000, 1'b1, 16'h000E, 16'h000E, 4);
    issue(16'hA025, 1'b1, 16'hFFFF, 16'hFFFF, 4);
    drain();
    mid_reset(16'h2061, 1'b1, 16'h0003, 16'h0003);
    drain();
`else
    issue(16'h00A1, 1'b0, '0, '0, 0);
    issue(16'h2061, 1'b0, '0, '0, 4);
    issue(16'h0404, 1'b1, 16'h0000, 16'h0000, 4);
    issue(16'h001C, 1'b1, 16'h0000, 16'h0000, 4);
    issue(16'h00A3, 1'b0, '0, '0, 4);
    drain();
    idle_window(10);
    issue(16'h80E1, 1'b0, '0, '0, 0);
    issue(16'h9000, 1'b1, 16'h0000, 16'h0000, 4);
    issue(16'hA025, 1'b0, '0, '0, 4);
    drain();
    mid_reset(16'h2061, 1'b0, '0, '0);
    drain();
`endif
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/bitty_core.md
# bitty_core

Parametrised multi-cycle Bitty processor core: 16-bit instruction input with a valid/ready handshake, and a register file of NUM_REGS entries, each DATA_W bits wide. It also has an internal S operand register, an ALU and a C result register. Each instruction runs through a four-state sequencer (IDLE, LOAD, EXEC, WB) and writes its result back to the destination register rx. This core replaces the fixed 8×16 top-level datapath and adds back-pressure and an immediate operand format.

## Interface
- DATA_W, 16, register/ALU width; legal range 8..32.
- NUM_REGS, 8, register-file depth; must be a power of 2 in the range 2..8.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- instruction  input  16  instruction word; sampled only on acceptance.
- inst_valid  input  1  instruction is present.
- inst_ready  output  1  core is able to accept an instruction (high in IDLE only).
- done  output  1  one-cycle pulse when an instruction retires.
- reg_flat  output  NUM_REGS*DATA_W  register file; entry i occupies bits [i*DATA_W +: DATA_W].
- reg_c  output  DATA_W  C result register.

## Operation
- Encoding fields:
  - [15:13] rx, destination and first operand.
  - [12:10] ry.
  - [12:5] imm8.
  - [4:2] op.
  - [1:0] fmt.
  - rx and ry use only their low log2(NUM_REGS) bits, so indices wrap modulo NUM_REGS.
- fmt values:
  - 00: operand B = R[ry]; bits [9:5] are ignored.
  - 01: operand B = zero-extended imm8.
  - 10 and 11: reserved.
- op values (A = S, B = operand; all arithmetic modulo 2^DATA_W; no carry or flags):
  - 000: A+B.
  - 001: A−B.
  - 010: A&B.
  - 011: A|B.
  - 100: A^B.
  - 101: A<<B[log2(DATA_W)-1:0].
  - 110: A>>B[log2(DATA_W)-1:0], logical.
  - 111: unsigned compare; result is 0 if A==B, 1 if A>B, 2 if A<B.
- FSM states:
  - IDLE: inst_ready=1. When inst_valid and inst_ready are both high, latch the instruction and go to LOAD.
  - LOAD: S <= R[rx]; go to EXEC.
  - EXEC: C <= ALU(S, B); go to WB. B is read from the register file in this cycle.
  - WB: R[rx] <= C; done <= 1; go to IDLE.
- Reserved fmt: the instruction still walks through all four states and done still pulses. C and the register file are left unchanged.
- When inst_valid is low in IDLE, the core holds its state and all registers hold their values.
- Reset (asynchronous, active-low) sets:
  - all R[i], S, C and the latched instruction to 0;
  - state to IDLE;
  - done to 0 and inst_ready to 1.
- If reset is asserted mid-instruction, the instruction is discarded, no write-back occurs and no done pulse is produced.

## Timing
- Acceptance at rising edge k.
- S is loaded at edge k+1.
- C is loaded at edge k+2.
- R[rx] is written and done rises at edge k+3.
- done stays high for exactly one cycle, during k+3..k+4. inst_ready is high in that same cycle.
- Throughput is one instruction per 4 cycles. A back-to-back instruction is accepted at edge k+4.
- A dependent instruction issued at k+4 reads the value written at k+3; no hazard logic is required.
- reg_c changes only at EXEC edges. reg_flat changes only at WB edges.
- The first acceptance after reset release can occur at the first rising edge at which reset is high.

## Configuration
- BITTY_IMM_EN defined: fmt 01 is the immediate format described above.
- BITTY_IMM_EN undefined: fmt 01 is treated as reserved, i.e. a no-op that still pulses done with the same latency. The imm8 path and its mux are not built.

## Test plan
All scenarios use DATA_W=16, NUM_REGS=8 and BITTY_IMM_EN defined, except the last one.
- Reset and immediates: after reset, reg_flat=0 and inst_ready=1. Issue 0x00A1 (R0+=5) then 0x2061 (R1+=3), each with inst_valid held. Required: R0=5, R1=3, reg_c=3, each done exactly 3 cycles after its acceptance edge.
- Register subtract and wrap-around:
  - 0x0404 (R0=R0−R1): R0=2.
  - 0x4404 (R2=R2−R1): R2=0xFFFD.
- Compare: 0x201C with R1=3, R0=2 gives R1=1. 0x001C with R0=2, R0=2 gives R0=0.
- Back-pressure: hold inst_valid low for 10 cycles in IDLE. Required: no state change and done=0. Then assert inst_valid with back-to-back instructions. Required: accepts exactly every 4 cycles; inst_ready is low in LOAD, EXEC and WB.
- Reset mid-instruction: assert reset during EXEC of 0x00A1. Required: R0=0, no done pulse, inst_ready=1 at the first edge after release.
- Reserved format and macro off:
  - 0x00A3 (fmt 11): done pulses, registers unchanged.
  - Rebuild without BITTY_IMM_EN, then issue 0x00A1: done pulses and R0 stays 0.
